// File: rtl/pixel_clip_fifo_pkg.sv
// Shared pixel type, drain FSM states and screen geometry for the clipping pixel FIFO.
package pixel_clip_fifo_pkg;

   localparam int unsigned ScreenW = 160;
   localparam int unsigned ScreenH = 120;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] colour;
   } pixel_t;

   localparam int unsigned PixelW = $bits(pixel_t);

   typedef enum logic [1:0] {
      StIdle,
      StActive,
      StDrain,
      StFinished
   } drain_state_e;

   function automatic logic pixel_in_bounds(input pixel_t p, input int unsigned h_res,
                                            input int unsigned v_res);
      return (32'(p.x) < h_res) && (32'(p.y) < v_res);
   endfunction

endpackage

// File: rtl/pixel_clip_fifo_if.sv
// Pixel stream between drawing engine, clipping FIFO and VGA adapter.
interface pixel_clip_fifo_if;

   logic [7:0] in_x;
   logic [6:0] in_y;
   logic [2:0] in_colour;
   logic       in_plot;
   logic       in_done;

   logic [7:0] out_x;
   logic [6:0] out_y;
   logic [2:0] out_colour;
   logic       out_plot;
   logic       out_ready;
   logic       out_done;

   // Environment side: drives the engine inputs and the adapter ready.
   modport master (
      output in_x, in_y, in_colour, in_plot, in_done, out_ready,
      input  out_x, out_y, out_colour, out_plot, out_done
   );

   // FIFO side.
   modport slave (
      input  in_x, in_y, in_colour, in_plot, in_done, out_ready,
      output out_x, out_y, out_colour, out_plot, out_done
   );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers; storage is not reset.
module sync_fifo #(
   parameter int unsigned Width = 18,
   parameter int unsigned Depth = 16,
   localparam int unsigned Aw = $clog2(Depth)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [Width-1:0] wdata,
   output logic [Width-1:0] rdata,
   output logic [Aw:0]      level,
   output logic             full,
   output logic             empty
);

   localparam logic [Aw:0] PtrOne = {{Aw{1'b0}}, 1'b1};
   localparam logic [Aw:0] WrapOnly = {1'b1, {Aw{1'b0}}};

   logic [Width-1:0] mem [Depth];
   logic [Aw:0]      wptr_q, wptr_d;
   logic [Aw:0]      rptr_q, rptr_d;
   logic             do_push;
   logic             do_pop;

   assign empty = (wptr_q == rptr_q);
   // Same slot index but opposite lap bit means the writer is a full lap ahead.
   assign full  = ((wptr_q ^ rptr_q) == WrapOnly);
   assign level = wptr_q - rptr_q;

   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & (~full | do_pop) & ~flush;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + PtrOne;
         if (do_pop)  rptr_d = rptr_q + PtrOne;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q[Aw-1:0]] <= wdata;
   end

   assign rdata = mem[rptr_q[Aw-1:0]];

   a_level_bound : assert property (@(posedge clk) disable iff (rst) 32'(level) <= Depth);
   a_full_not_empty : assert property (@(posedge clk) disable iff (rst) full |-> !empty);

endmodule

// File: rtl/pixel_clip_fifo.sv
// Clips off-screen pixels, buffers on-screen ones for the VGA adapter and tracks drain completion.
module pixel_clip_fifo
   import pixel_clip_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned H_RES = ScreenW,
   parameter int unsigned V_RES = ScreenH,
   localparam int unsigned Aw = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               clear_err,
   pixel_clip_fifo_if.slave   pix,
   output logic [Aw:0]        level,
   output logic               full,
   output logic               empty,
   output logic               overflow,
   output logic [7:0]         clip_count
);

   localparam logic [Aw:0] LevelOne = {{Aw{1'b0}}, 1'b1};

   pixel_t       in_px;
   pixel_t       head_px;
   logic         in_bounds;
   logic         push;
   logic         pop;
   logic         ovf_event;
   logic         clip_event;
   logic         empty_next;
   logic         overflow_q, overflow_d;
   logic [7:0]   clip_q, clip_d;
   drain_state_e state_q, state_d;

   assign in_px     = '{x: pix.in_x, y: pix.in_y, colour: pix.in_colour};
   assign in_bounds = pixel_in_bounds(in_px, H_RES, V_RES);

   assign pop        = ~empty & pix.out_ready;
   assign push       = pix.in_plot & in_bounds & ~flush & (~full | pop);
   assign ovf_event  = pix.in_plot & in_bounds & ~flush & full & ~pop;
   assign clip_event = pix.in_plot & ~in_bounds;

   // Occupancy after this edge; covers the last entry leaving with nothing arriving.
   assign empty_next = flush | ((empty | ((level == LevelOne) & pop)) & ~push);

   sync_fifo #(
      .Width (PixelW),
      .Depth (DEPTH)
   ) u_sync_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .wdata (in_px),
      .rdata (head_px),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   assign pix.out_x      = head_px.x;
   assign pix.out_y      = head_px.y;
   assign pix.out_colour = head_px.colour;
   assign pix.out_plot   = ~empty;

   // A fresh event in the same cycle as clear_err must survive the clear.
   always_comb begin
      overflow_d = overflow_q;
      clip_d     = clip_q;
      if (ovf_event) begin
         overflow_d = 1'b1;
      end else if (clear_err) begin
         overflow_d = 1'b0;
      end
      if (clip_event) begin
         if (clear_err) begin
            clip_d = 8'd1;
         end else if (clip_q != 8'hFF) begin
            clip_d = clip_q + 8'd1;
         end
      end else if (clear_err) begin
         clip_d = 8'd0;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (pix.in_done && empty_next) begin
               state_d = StFinished;
            end else if (push) begin
               state_d = StActive;
            end
         end
         StActive: begin
            if (pix.in_done) begin
               state_d = empty_next ? StFinished : StDrain;
            end
         end
         StDrain: begin
            if (flush || empty_next) state_d = StFinished;
         end
         StFinished: begin
            if (!pix.in_done) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q <= 1'b0;
         clip_q     <= 8'd0;
         state_q    <= StIdle;
      end else begin
         overflow_q <= overflow_d;
         clip_q     <= clip_d;
         state_q    <= state_d;
      end
   end

   assign overflow     = overflow_q;
   assign clip_count   = clip_q;
   assign pix.out_done = (state_q == StFinished);

   a_ovf_sticks : assert property (@(posedge clk) disable iff (rst) ovf_event |=> overflow);
   a_push_on_screen : assert property (@(posedge clk) disable iff (rst) push |-> in_bounds);

endmodule

// File: tb/tb_pixel_clip_fifo.sv
// Scoreboard bench for pixel_clip_fifo: expected pixels queued at drive time, checked as they pop.
module tb_pixel_clip_fifo;

   localparam int Depth = 16;
   localparam int HRes  = 160;
   localparam int VRes  = 120;

   logic       clk;
   logic       rst;
   logic       flush_s;
   logic       clear_s;
   logic       done_s;
   logic [4:0] level;
   logic       full;
   logic       empty;
   logic       overflow;
   logic [7:0] clip_count;

   int total;
   int bad;

   logic [17:0] exp_q [$];
   logic        exp_ovf;
   logic [7:0]  exp_clip;

   pixel_clip_fifo_if pix ();

   pixel_clip_fifo #(
      .DEPTH (Depth),
      .H_RES (HRes),
      .V_RES (VRes)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush_s),
      .clear_err  (clear_s),
      .pix        (pix),
      .level      (level),
      .full       (full),
      .empty      (empty),
      .overflow   (overflow),
      .clip_count (clip_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: a pop happens on the coming edge, so the head must match the oldest expectation.
   always @(negedge clk) begin
      logic [17:0] got;
      if (!rst && !flush_s && pix.out_plot && pix.out_ready) begin
         got = {pix.out_x, pix.out_y, pix.out_colour};
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_spurious: popped %h, expected no pixel", got);
         end else begin
            if (got !== exp_q[0]) begin
               bad++;
               $display("FAIL sb_order: popped %h, expected %h", got, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic drive(input logic plot, input logic [7:0] x, input logic [6:0] y,
                        input logic [2:0] c, input logic rdy, input logic fl, input logic ce);
      logic inb, pop_now, clip_ev, ovf_ev;
      @(posedge clk);
      #1;
      pix.in_plot   = plot;
      pix.in_x      = x;
      pix.in_y      = y;
      pix.in_colour = c;
      pix.out_ready = rdy;
      pix.in_done   = done_s;
      flush_s       = fl;
      clear_s       = ce;
      inb     = (x < 8'(HRes)) && (y < 7'(VRes));
      pop_now = (exp_q.size() != 0) && rdy && !fl;
      clip_ev = plot && !inb;
      ovf_ev  = plot && inb && !fl && (exp_q.size() == Depth) && !pop_now;
      if (fl) exp_q.delete();
      else if (plot && inb && ((exp_q.size() < Depth) || pop_now)) exp_q.push_back({x, y, c});
      if (ovf_ev) exp_ovf = 1'b1;
      else if (ce) exp_ovf = 1'b0;
      if (clip_ev) exp_clip = ce ? 8'd1 : ((exp_clip == 8'hFF) ? exp_clip : exp_clip + 8'd1);
      else if (ce) exp_clip = 8'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({empty, full, level, pix.out_plot} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
         bad++;
         $display("FAIL reset_fifo: empty/full/level/plot=%b/%b/%0d/%b want 1/0/0/0",
                  empty, full, level, pix.out_plot);
      end
      total++;
      if ({overflow, clip_count, pix.out_done} !== {1'b0, 8'd0, 1'b0}) begin
         bad++;
         $display("FAIL reset_status: ovf/clip/done=%b/%0d/%b want 0/0/0",
                  overflow, clip_count, pix.out_done);
      end
      exp_q.delete();
      exp_ovf  = 1'b0;
      exp_clip = 8'd0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_single();
      drive(1'b1, 8'd10, 7'd20, 3'd5, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if (pix.out_plot !== 1'b0) begin
         bad++;
         $display("FAIL single_latency: out_plot=%b in push cycle, want 0", pix.out_plot);
      end
      drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if ({pix.out_plot, pix.out_x, pix.out_y, pix.out_colour} !== {1'b1, 8'd10, 7'd20, 3'd5}) begin
         bad++;
         $display("FAIL single_head: plot=%b px=(%0d,%0d,%0d) want 1 (10,20,5)",
                  pix.out_plot, pix.out_x, pix.out_y, pix.out_colour);
      end
      drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if (empty !== 1'b1) begin
         bad++;
         $display("FAIL single_empty: empty=%b want 1", empty);
      end
   endtask

   task automatic test_overflow();
      int n;
      for (int i = 0; i < 17; i++) drive(1'b1, 8'(i), 7'(i + 1), 3'(i), 1'b0, 1'b0, 1'b0);
      drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if ({full, level, overflow} !== {1'b1, 5'd16, 1'b1}) begin
         bad++;
         $display("FAIL ovf_full: full/level/ovf=%b/%0d/%b want 1/16/1", full, level, overflow);
      end
      n = 0;
      while (exp_q.size() != 0 && n < 64) begin
         drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, 1'b0);
         n++;
      end
      @(negedge clk);
      total++;
      if (exp_q.size() != 0 || empty !== 1'b1) begin
         bad++;
         $display("FAIL ovf_drain: left=%0d empty=%b want 0 and 1", exp_q.size(), empty);
      end
      total++;
      if (overflow !== exp_ovf) begin
         bad++;
         $display("FAIL ovf_sticky: overflow=%b want %b", overflow, exp_ovf);
      end
      drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if (overflow !== 1'b0) begin
         bad++;
         $display("FAIL ovf_clear: overflow=%b want 0", overflow);
      end
   endtask

   task automatic test_clip();
      int n;
      drive(1'b1, 8'd159, 7'd119, 3'd6, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'd160, 7'd0, 3'd1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'd0, 7'd120, 3'd2, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if ({clip_count, level} !== {8'd2, 5'd1}) begin
         bad++;
         $display("FAIL clip_edge: clip=%0d level=%0d want 2 and 1", clip_count, level);
      end
      n = 0;
      while (exp_q.size() != 0 && n < 8) begin
         drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, 1'b0);
         n++;
      end
      for (int i = 0; i < 260; i++) drive(1'b1, 8'd200, 7'(i), 3'd3, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if (clip_count !== 8'd255) begin
         bad++;
         $display("FAIL clip_sat: clip=%0d want 255", clip_count);
      end
      drive(1'b1, 8'd0, 7'd127, 3'd0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if (clip_count !== exp_clip) begin
         bad++;
         $display("FAIL clip_clear_race: clip=%0d want %0d", clip_count, exp_clip);
      end
      drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_full_wrap();
      int n;
      for (int i = 0; i < 16; i++) drive(1'b1, 8'(100 + i), 7'(i), 3'(i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) drive(1'b1, 8'(50 + i), 7'(90 + i), 3'(i + 3), 1'b1, 1'b0, 1'b0);
      drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if ({full, level, overflow} !== {1'b1, 5'd16, 1'b0}) begin
         bad++;
         $display("FAIL wrap_full: full/level/ovf=%b/%0d/%b want 1/16/0", full, level, overflow);
      end
      n = 0;
      while (exp_q.size() != 0 && n < 64) begin
         drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, 1'b0);
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL wrap_drain: left=%0d want 0", exp_q.size());
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) drive(1'b1, 8'(i), 7'(i), 3'(i), 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'd250, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'd1, 7'd1, 3'd1, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if ({level, empty, pix.out_plot} !== {5'd0, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL flush_empty: level/empty/plot=%0d/%b/%b want 0/1/0",
                  level, empty, pix.out_plot);
      end
      total++;
      if (clip_count !== exp_clip || overflow !== exp_ovf) begin
         bad++;
         $display("FAIL flush_keep: clip=%0d ovf=%b want %0d %b",
                  clip_count, overflow, exp_clip, exp_ovf);
      end
      drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_done();
      logic want;
      for (int i = 0; i < 3; i++) drive(1'b1, 8'(20 + i), 7'(40 + i), 3'(7 - i), 1'b0, 1'b0, 1'b0);
      done_s = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, 1'b0);
         @(negedge clk);
         want = (i == 4);
         total++;
         if (pix.out_done !== want) begin
            bad++;
            $display("FAIL done_rise[%0d]: out_done=%b want %b", i, pix.out_done, want);
         end
      end
      done_s = 1'b0;
      drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if (pix.out_done !== 1'b0) begin
         bad++;
         $display("FAIL done_fall: out_done=%b want 0", pix.out_done);
      end
   endtask

   task automatic test_reset_mid_drain();
      for (int i = 0; i < 5; i++) drive(1'b1, 8'(60 + i), 7'(i), 3'(i), 1'b0, 1'b0, 1'b0);
      done_s = 1'b1;
      drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if ({level, pix.out_done} !== {5'd5, 1'b0}) begin
         bad++;
         $display("FAIL drain_pre: level=%0d done=%b want 5 and 0", level, pix.out_done);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({empty, pix.out_plot, pix.out_done, level} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
         bad++;
         $display("FAIL rst_async: empty/plot/done/level=%b/%b/%b/%0d want 1/0/0/0",
                  empty, pix.out_plot, pix.out_done, level);
      end
      exp_q.delete();
      exp_ovf  = 1'b0;
      exp_clip = 8'd0;
      done_s = 1'b0;
      pix.in_done = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if ({pix.out_plot, pix.out_done} !== 2'b00) begin
         bad++;
         $display("FAIL rst_after: plot=%b done=%b want 0 0", pix.out_plot, pix.out_done);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      flush_s = 1'b0;
      clear_s = 1'b0;
      done_s = 1'b0;
      exp_ovf = 1'b0;
      exp_clip = 8'd0;
      pix.in_x = '0;
      pix.in_y = '0;
      pix.in_colour = '0;
      pix.in_plot = 1'b0;
      pix.in_done = 1'b0;
      pix.out_ready = 1'b0;
      test_reset();
      test_single();
      test_overflow();
      test_clip();
      test_full_wrap();
      test_flush();
      test_done();
      test_reset_mid_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
